// File: rtl/water_level_if.sv
//------------------------------------------------------------------------------
// Module      : water_level_if
// Description : Sensor-in / level-code-out bundle of the water level encoder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface water_level_if;
  logic [2:0] sensors;
  logic [1:0] data;
  logic       valid;
  logic       fault;
  logic       changed;

  modport master (output sensors, input data, input valid, input fault, input changed);
  modport slave  (input sensors, output data, output valid, output fault, output changed);
endinterface

`default_nettype wire

// File: rtl/water_level_encoder.sv
//------------------------------------------------------------------------------
// Module      : water_level_encoder
// Description : Synchronises, debounces and encodes three tank float sensors.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module water_level_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  water_level_if.slave    bus
);

  localparam logic [CNT_W-1:0] c_DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_START_LAST = CNT_W'(DEBOUNCE_CYCLES + 2);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       w_stable;
  logic [CNT_W-1:0] r_start_cnt;
  logic             w_start_done;
  state_t           r_state;
  state_t           w_state_next;
  logic [1:0]       r_data;
  logic [1:0]       w_data_next;
  logic             r_changed;
  logic             w_changed_next;
  logic [1:0]       w_code;
  logic             w_code_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= bus.sensors;
      r_sync2 <= r_sync1;
    end
  end

  // Independent debounce per sensor; the counter never passes the last value.
  for (genvar gi = 0; gi < 3; gi++) begin : g_deb
    logic [CNT_W-1:0] r_cnt;
    logic             r_stb;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt <= '0;
        r_stb <= 1'b0;
      end else if (r_sync2[gi] == r_stb) begin
        r_cnt <= '0;
      end else if (r_cnt >= c_DEB_LAST) begin
        r_stb <= r_sync2[gi];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_stable[gi] = r_stb;
  end

  assign w_start_done = (r_start_cnt == c_START_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_cnt <= '0;
    end else if ((r_state == S_INIT) && !w_start_done) begin
      r_start_cnt <= r_start_cnt + 1'b1;
    end
  end

  always_comb begin
    w_code    = 2'b00;
    w_code_ok = 1'b0;
    case (w_stable)
      3'b000:  begin w_code = 2'b00; w_code_ok = 1'b1; end
      3'b001:  begin w_code = 2'b01; w_code_ok = 1'b1; end
      3'b011:  begin w_code = 2'b10; w_code_ok = 1'b1; end
      3'b111:  begin w_code = 2'b11; w_code_ok = 1'b1; end
      default: begin w_code = 2'b00; w_code_ok = 1'b0; end
    endcase
  end

  always_comb begin
    w_state_next   = r_state;
    w_data_next    = r_data;
    w_changed_next = 1'b0;
    case (r_state)
      // The startup load is the first known level, not a change, so no strobe.
      S_INIT: begin
        w_data_next = 2'b00;
        if (w_start_done) begin
          w_state_next = w_code_ok ? S_RUN : S_FAULT;
          w_data_next  = w_code_ok ? w_code : 2'b00;
        end
      end
      S_RUN: begin
        if (w_code_ok) begin
          w_data_next = w_code;
        end else begin
          w_state_next = S_FAULT;
          w_data_next  = 2'b00;
        end
        w_changed_next = (w_data_next != r_data);
      end
      S_FAULT: begin
        w_data_next = 2'b00;
        if (w_code_ok) begin
          w_state_next = S_RUN;
          w_data_next  = w_code;
        end
        w_changed_next = (w_data_next != r_data);
      end
      default: begin
        w_state_next = S_INIT;
        w_data_next  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_INIT;
      r_data    <= 2'b00;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_data    <= w_data_next;
      r_changed <= w_changed_next;
    end
  end

  assign bus.data    = r_data;
  assign bus.valid   = (r_state == S_RUN);
  assign bus.fault   = (r_state == S_FAULT);
  assign bus.changed = r_changed;

endmodule

`default_nettype wire

// File: tb/tb_water_level_encoder.sv
//------------------------------------------------------------------------------
// Module      : tb_water_level_encoder
// Description : Directed self-checking bench for water_level_encoder (DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_water_level_encoder;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  water_level_if u_if ();

  water_level_encoder #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector layout: {data[1:0], valid, fault, changed}
  function automatic logic [4:0] obs();
    return {u_if.data, u_if.valid, u_if.fault, u_if.changed};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    u_if.sensors = 3'b111;
    tick(2);
    checks++;
    if (obs() !== 5'b00_0_0_0) begin
      errors++;
      $display("FAIL reset_state: got %b expected %b", obs(), 5'b00_0_0_0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++;
      if (obs() !== 5'b00_0_0_0) begin
        errors++;
        $display("FAIL init_hold cycle %0d: got %b expected %b", i, obs(), 5'b00_0_0_0);
      end
    end
    tick(1);
    checks++;
    if (obs() !== 5'b11_1_0_0) begin
      errors++;
      $display("FAIL init_load: got %b expected %b", obs(), 5'b11_1_0_0);
    end
    tick(3);
    checks++;
    if (obs() !== 5'b11_1_0_0) begin
      errors++;
      $display("FAIL run_steady_high: got %b expected %b", obs(), 5'b11_1_0_0);
    end
  endtask

  task automatic test_level_change();
    u_if.sensors = 3'b011;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      checks++;
      if (obs() !== 5'b11_1_0_0) begin
        errors++;
        $display("FAIL change_latency cycle %0d: got %b expected %b", i, obs(), 5'b11_1_0_0);
      end
    end
    tick(1);
    checks++;
    if (obs() !== 5'b10_1_0_1) begin
      errors++;
      $display("FAIL change_to_mid: got %b expected %b", obs(), 5'b10_1_0_1);
    end
    tick(1);
    checks++;
    if (obs() !== 5'b10_1_0_0) begin
      errors++;
      $display("FAIL changed_one_cycle: got %b expected %b", obs(), 5'b10_1_0_0);
    end
  endtask

  task automatic test_glitch();
    u_if.sensors = 3'b111;
    tick(3);
    u_if.sensors = 3'b011;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      checks++;
      if (obs() !== 5'b10_1_0_0) begin
        errors++;
        $display("FAIL glitch_reject cycle %0d: got %b expected %b", i, obs(), 5'b10_1_0_0);
      end
    end
  endtask

  task automatic test_fault_recover();
    u_if.sensors = 3'b101;
    tick(6);
    checks++;
    if (obs() !== 5'b10_1_0_0) begin
      errors++;
      $display("FAIL fault_early: got %b expected %b", obs(), 5'b10_1_0_0);
    end
    tick(1);
    checks++;
    if (obs() !== 5'b00_0_1_1) begin
      errors++;
      $display("FAIL fault_entry: got %b expected %b", obs(), 5'b00_0_1_1);
    end
    u_if.sensors = 3'b001;
    tick(1);
    checks++;
    if (obs() !== 5'b00_0_1_0) begin
      errors++;
      $display("FAIL fault_hold: got %b expected %b", obs(), 5'b00_0_1_0);
    end
    tick(6);
    checks++;
    if (obs() !== 5'b01_1_0_1) begin
      errors++;
      $display("FAIL fault_recover: got %b expected %b", obs(), 5'b01_1_0_1);
    end
    tick(1);
    checks++;
    if (obs() !== 5'b01_1_0_0) begin
      errors++;
      $display("FAIL recover_pulse_end: got %b expected %b", obs(), 5'b01_1_0_0);
    end
  endtask

  task automatic test_mid_reset();
    tick(2);
    reset = 1'b1;
    tick(1);
    checks++;
    if (obs() !== 5'b00_0_0_0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected %b", obs(), 5'b00_0_0_0);
    end
    reset = 1'b0;
    tick(6);
    checks++;
    if (obs() !== 5'b00_0_0_0) begin
      errors++;
      $display("FAIL reinit_hold: got %b expected %b", obs(), 5'b00_0_0_0);
    end
    tick(1);
    checks++;
    if (obs() !== 5'b01_1_0_0) begin
      errors++;
      $display("FAIL reinit_load: got %b expected %b", obs(), 5'b01_1_0_0);
    end
  endtask

  task automatic test_init_fault();
    reset = 1'b1;
    u_if.sensors = 3'b110;
    tick(2);
    reset = 1'b0;
    tick(7);
    checks++;
    if (obs() !== 5'b00_0_1_0) begin
      errors++;
      $display("FAIL init_fault: got %b expected %b", obs(), 5'b00_0_1_0);
    end
    tick(10);
    checks++;
    if (obs() !== 5'b00_0_1_0) begin
      errors++;
      $display("FAIL init_fault_stays: got %b expected %b", obs(), 5'b00_0_1_0);
    end
    u_if.sensors = 3'b111;
    tick(7);
    checks++;
    if (obs() !== 5'b11_1_0_1) begin
      errors++;
      $display("FAIL init_fault_recover: got %b expected %b", obs(), 5'b11_1_0_1);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    u_if.sensors = 3'b000;
    test_reset();
    test_level_change();
    test_glitch();
    test_fault_recover();
    test_mid_reset();
    test_init_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
